// File: rtl/sseg_scan_capture.sv
// Monitor for a 4-digit multiplexed seven-segment display. It samples the anode and
// cathode lines once per settled dwell and recovers the displayed hex digits and scan faults.
module sseg_scan_capture #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [6:0]  seg_in,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        bad_anode,
    output logic        code_err,
    output logic        stalled
);

    localparam int unsigned SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SETTLE_C  = SET_W'(SETTLE);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {ST_WAIT, ST_SAMPLE, ST_HOLD} state_t;

    logic [3:0]       r_an_s1, r_an_s2;
    logic [6:0]       r_seg_s1, r_seg_s2;
    logic [SET_W-1:0] r_settle;
    logic [3:0]       r_seen;
    logic [CNT_W-1:0] r_to_cnt;
    state_t           r_state;

    state_t           w_state_next;
    logic             w_change;
    logic [SET_W-1:0] w_settle_next;
    logic             w_sample;
    logic             w_an_legal;
    logic             w_an_idle;
    logic [1:0]       w_idx;
    logic [6:0]       w_seg_hi;
    logic [3:0]       w_hex;
    logic             w_hex_ok;
    logic             w_capture;
    logic [3:0]       w_seen_next;
    logic [CNT_W-1:0] w_to_next;

    // Two-flop synchronisers, preset to the idle (all-off) pin state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an_s1  <= 4'b1111;
            r_an_s2  <= 4'b1111;
            r_seg_s1 <= 7'b1111111;
            r_seg_s2 <= 7'b1111111;
        end else begin
            r_an_s1  <= anode_in;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= seg_in;
            r_seg_s2 <= r_seg_s1;
        end
    end

    // A change is seen one cycle early so the sample lands at edge SETTLE+2
    assign w_change = {r_an_s1, r_seg_s1} != {r_an_s2, r_seg_s2};

    always_comb begin
        w_settle_next = r_settle;
        if (w_change) begin
            w_settle_next = '0;
        end else if (r_settle != SETTLE_C) begin
            w_settle_next = r_settle + SET_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_settle <= '0;
            r_state  <= ST_WAIT;
        end else begin
            r_settle <= w_settle_next;
            r_state  <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT:   if (w_settle_next == SETTLE_C) w_state_next = ST_SAMPLE;
            ST_SAMPLE: w_state_next = w_change ? ST_WAIT : ST_HOLD;
            ST_HOLD:   if (w_change) w_state_next = ST_WAIT;
            default:   w_state_next = ST_WAIT;
        endcase
    end

    assign w_sample = (r_state == ST_SAMPLE);

    always_comb begin
        w_an_legal = 1'b1;
        w_an_idle  = 1'b0;
        w_idx      = 2'd0;
        case (r_an_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            4'b1111: begin w_an_legal = 1'b0; w_an_idle = 1'b1; end
            default: w_an_legal = 1'b0;
        endcase
    end

    assign w_seg_hi = ~r_seg_s2;

    always_comb begin
        w_hex    = 4'h0;
        w_hex_ok = 1'b1;
        case (w_seg_hi)
            7'h3F: w_hex = 4'h0;
            7'h06: w_hex = 4'h1;
            7'h5B: w_hex = 4'h2;
            7'h4F: w_hex = 4'h3;
            7'h66: w_hex = 4'h4;
            7'h6D: w_hex = 4'h5;
            7'h7D: w_hex = 4'h6;
            7'h07: w_hex = 4'h7;
            7'h7F: w_hex = 4'h8;
            7'h6F: w_hex = 4'h9;
            7'h77: w_hex = 4'hA;
            7'h7C: w_hex = 4'hB;
            7'h39: w_hex = 4'hC;
            7'h5E: w_hex = 4'hD;
            7'h79: w_hex = 4'hE;
            7'h71: w_hex = 4'hF;
            default: w_hex_ok = 1'b0;
        endcase
    end

    assign w_capture   = w_sample && w_an_legal;
    assign w_seen_next = r_seen | 4'(4'b0001 << w_idx);
    assign w_to_next   = (r_to_cnt == TIMEOUT_C) ? TIMEOUT_C : r_to_cnt + CNT_W'(1);

    // Capture, frame tracking and stall timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits      <= '0;
            digit_valid <= '0;
            blank       <= '0;
            frame_done  <= 1'b0;
            bad_anode   <= 1'b0;
            code_err    <= 1'b0;
            stalled     <= 1'b0;
            r_seen      <= '0;
            r_to_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            bad_anode  <= w_sample && !w_an_legal && !w_an_idle;
            code_err   <= 1'b0;
            if (w_capture) begin
                digits[{w_idx, 2'b00} +: 4] <= w_hex_ok ? w_hex : 4'h0;
                digit_valid[w_idx]          <= w_hex_ok;
                blank[w_idx]                <= (w_seg_hi == 7'h00);
                code_err                    <= !w_hex_ok && (w_seg_hi != 7'h00);
                if (w_seen_next == 4'b1111) begin
                    frame_done <= 1'b1;
                    r_seen     <= '0;
                end else begin
                    r_seen <= w_seen_next;
                end
                r_to_cnt <= '0;
                stalled  <= 1'b0;
            end else begin
                r_to_cnt <= w_to_next;
                if (w_to_next == TIMEOUT_C) stalled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: table of settled dwells plus hand-written
// sequences for glitches, mid-scan reset and stall recovery.
module tb_sseg_scan_capture;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 200;
    localparam int unsigned CNT_W   = 8;
    localparam int          NVEC    = 18;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  anode_in;
    logic [6:0]  seg_in;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic [3:0]  blank;
    logic        frame_done;
    logic        bad_anode;
    logic        code_err;
    logic        stalled;

    int n_tests = 0;
    int n_fail  = 0;
    int fd_cnt, bad_cnt, err_cnt, fd_edge;
    int tot_fd, quiet_viol;
    logic st5, st6;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [15:0] dig;
        logic [3:0]  val;
        logic [3:0]  blk;
        int          bad;
        int          err;
        int          fd;
    } vec_t;

    vec_t tbl [NVEC];

    sseg_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .anode_in(anode_in), .seg_in(seg_in),
        .digits(digits), .digit_valid(digit_valid), .blank(blank),
        .frame_done(frame_done), .bad_anode(bad_anode), .code_err(code_err),
        .stalled(stalled)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hold one pin pattern for n edges (edge 0 is the first to see it), counting pulses
    task automatic dwell(input logic [3:0] an, input logic [6:0] sg, input int n);
        anode_in = an;
        seg_in   = sg;
        fd_cnt = 0; bad_cnt = 0; err_cnt = 0; fd_edge = -1;
        st5 = 1'b0; st6 = 1'b0;
        for (int e = 0; e < n; e++) begin
            tick();
            if (frame_done) begin
                fd_cnt++;
                if (fd_edge < 0) fd_edge = e;
            end
            if (bad_anode) bad_cnt++;
            if (code_err) err_cnt++;
            if (e == 5) st5 = stalled;
            if (e == 6) st6 = stalled;
        end
        tot_fd += fd_cnt;
    endtask

    function automatic logic [31:0] all_outs();
        return {4'h0, digits, digit_valid, blank, frame_done, bad_anode, code_err, stalled};
    endfunction

    initial begin
        tbl[0]  = '{4'b1100, 7'h79, 16'h4321, 4'hF, 4'h0, 1, 0, 0};
        tbl[1]  = '{4'b0111, 7'h7F, 16'h0321, 4'h7, 4'h8, 0, 0, 0};
        tbl[2]  = '{4'b1011, 7'h55, 16'h0021, 4'h3, 4'h8, 0, 1, 0};
        tbl[3]  = '{4'b1111, 7'h00, 16'h0021, 4'h3, 4'h8, 0, 0, 0};
        tbl[4]  = '{4'b1110, 7'h08, 16'h002A, 4'h3, 4'h8, 0, 0, 0};
        tbl[5]  = '{4'b1110, 7'h03, 16'h002B, 4'h3, 4'h8, 0, 0, 0};
        tbl[6]  = '{4'b1101, 7'h46, 16'h00CB, 4'h3, 4'h8, 0, 0, 1};
        tbl[7]  = '{4'b1011, 7'h21, 16'h0DCB, 4'h7, 4'h8, 0, 0, 0};
        tbl[8]  = '{4'b0111, 7'h06, 16'hEDCB, 4'hF, 4'h0, 0, 0, 0};
        tbl[9]  = '{4'b1110, 7'h0E, 16'hEDCF, 4'hF, 4'h0, 0, 0, 0};
        tbl[10] = '{4'b1101, 7'h40, 16'hED0F, 4'hF, 4'h0, 0, 0, 1};
        tbl[11] = '{4'b1011, 7'h02, 16'hE60F, 4'hF, 4'h0, 0, 0, 0};
        tbl[12] = '{4'b1010, 7'h02, 16'hE60F, 4'hF, 4'h0, 1, 0, 0};
        tbl[13] = '{4'b1111, 7'h7F, 16'hE60F, 4'hF, 4'h0, 0, 0, 0};
        tbl[14] = '{4'b0111, 7'h12, 16'h560F, 4'hF, 4'h0, 0, 0, 0};
        tbl[15] = '{4'b1110, 7'h78, 16'h5607, 4'hF, 4'h0, 0, 0, 0};
        tbl[16] = '{4'b1101, 7'h00, 16'h5687, 4'hF, 4'h0, 0, 0, 1};
        tbl[17] = '{4'b1011, 7'h10, 16'h5987, 4'hF, 4'h0, 0, 0, 0};

        tot_fd   = 0;
        reset    = 1'b1;
        anode_in = 4'b1111;
        seg_in   = 7'h7F;
        tick();
        tick();
        check("reset_outputs", all_outs(), 32'h0);

        // Idle pins: quiet until TIMEOUT, then stalled
        reset = 1'b0;
        quiet_viol = 0;
        for (int e = 1; e < int'(TIMEOUT); e++) begin
            tick();
            if (all_outs() != 32'h0) quiet_viol++;
        end
        check("idle_quiet", 32'(quiet_viol), 32'h0);
        tick();
        check("idle_stalled", {31'h0, stalled}, 32'h1);
        check("idle_no_digits", {16'h0, digits}, 32'h0);

        // Basic scan of "4321"
        dwell(4'b1110, 7'h79, 20);
        check("scan_stall_before", {31'h0, st5}, 32'h1);
        check("scan_stall_cleared", {31'h0, st6}, 32'h0);
        check("scan_d0_nofd", 32'(fd_cnt), 32'h0);
        dwell(4'b1101, 7'h24, 20);
        dwell(4'b1011, 7'h30, 20);
        check("scan_3_nofd", 32'(tot_fd), 32'h0);
        dwell(4'b0111, 7'h19, 20);
        check("scan_fd_count", 32'(fd_cnt), 32'h1);
        check("scan_fd_edge", 32'(fd_edge), 32'd6);
        check("scan_digits", {16'h0, digits}, 32'h4321);
        check("scan_valid", {28'h0, digit_valid}, 32'hF);
        check("scan_blank", {28'h0, blank}, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            dwell(tbl[i].an, tbl[i].seg, 12);
            check($sformatf("v%0d_digits", i), {16'h0, digits}, {16'h0, tbl[i].dig});
            check($sformatf("v%0d_valid", i), {28'h0, digit_valid}, {28'h0, tbl[i].val});
            check($sformatf("v%0d_blank", i), {28'h0, blank}, {28'h0, tbl[i].blk});
            check($sformatf("v%0d_bad", i), 32'(bad_cnt), 32'(tbl[i].bad));
            check($sformatf("v%0d_err", i), 32'(err_cnt), 32'(tbl[i].err));
            check($sformatf("v%0d_fd", i), 32'(fd_cnt), 32'(tbl[i].fd));
        end

        // Short glitch on digit0 must not be sampled
        dwell(4'b1110, 7'h40, 3);
        dwell(4'b1101, 7'h19, 20);
        check("glitch_digits", {16'h0, digits}, 32'h5947);
        check("glitch_no_err", 32'(err_cnt + bad_cnt), 32'h0);

        // Async reset after three captures, then a clean frame
        dwell(4'b1110, 7'h79, 20);
        dwell(4'b1101, 7'h24, 20);
        dwell(4'b1011, 7'h30, 20);
        #3 reset = 1'b1;
        #1 check("midreset_outputs", all_outs(), 32'h0);
        tick();
        reset  = 1'b0;
        tot_fd = 0;
        dwell(4'b1110, 7'h00, 20);
        dwell(4'b1101, 7'h10, 20);
        dwell(4'b1011, 7'h08, 20);
        dwell(4'b0111, 7'h03, 20);
        check("after_reset_fd", 32'(tot_fd), 32'h1);
        check("after_reset_digits", {16'h0, digits}, 32'hBA98);
        check("after_reset_valid", {28'h0, digit_valid}, 32'hF);

        // Stall mid-frame; the frame-completing capture clears it on the same edge
        tot_fd = 0;
        dwell(4'b1110, 7'h40, 20);
        dwell(4'b1101, 7'h79, 20);
        dwell(4'b1011, 7'h24, 20);
        dwell(4'b1111, 7'h7F, 210);
        check("stall_set", {31'h0, stalled}, 32'h1);
        check("stall_no_fd_yet", 32'(tot_fd), 32'h0);
        dwell(4'b0111, 7'h30, 20);
        check("resume_stall_before", {31'h0, st5}, 32'h1);
        check("resume_stall_cleared", {31'h0, st6}, 32'h0);
        check("resume_fd_edge", 32'(fd_edge), 32'd6);
        check("resume_fd_count", 32'(fd_cnt), 32'h1);
        check("resume_digits", {16'h0, digits}, 32'h3210);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
